memory_stage: RTL

Pipeline memory-access stage: the consumer of the execute-to-memory (`ex_mem_*`) bundle. It registers non-memory results straight through to writeback. For loads and stores it runs a request/ready handshake with the data-memory port and stalls execute until the access completes or times out. It then presents the `mem_wb_*` bundle to the writeback stage.

---
 rtl/memory_stage_pkg.sv | 16 +
 rtl/mem_watchdog.sv | 35 +++
 rtl/memory_stage.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/memory_stage_pkg.sv
// Shared pipeline definitions for the memory-access stage: FSM encoding,
// data-memory direction constants and register index width.
package memory_stage_pkg;

    typedef enum logic {
        StIdle   = 1'b0,
        StAccess = 1'b1
    } state_e;

    localparam logic DmRead  = 1'b0;
    localparam logic DmWrite = 1'b1;

    localparam int unsigned RegIdxW = 5;
    localparam int unsigned WdogW   = 8;

endpackage

// File: rtl/mem_watchdog.sv
// Access timeout counter: counts enabled cycles since the last clear and flags
// the cycle on which the count has reached limit-1 (the abort edge).
module mem_watchdog
    import memory_stage_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [WdogW-1:0] limit,
    output logic             expired
);

    logic [WdogW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == (limit - 8'd1));

endmodule

// File: rtl/memory_stage.sv
// Pipeline memory-access stage: passes ALU results to writeback and runs the
// data-memory request/ready handshake (with timeout) for loads and stores.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ex_mem_readmem,
    input  logic               ex_mem_writemem,
    input  logic [DATA_W-1:0]  ex_mem_regb,
    input  logic               ex_mem_selwsource,
    input  logic [RegIdxW-1:0] ex_mem_regdest,
    input  logic               ex_mem_writereg,
    input  logic [DATA_W-1:0]  ex_mem_wbvalue,
    output logic               mem_dm_en,
    output logic               mem_dm_rw,
    output logic [DATA_W-1:0]  mem_dm_addr,
    output logic [DATA_W-1:0]  mem_dm_wdata,
    input  logic [DATA_W-1:0]  mem_dm_rdata,
    input  logic               mem_dm_ready,
    output logic               mem_ex_stall,
    output logic [RegIdxW-1:0] mem_wb_regdest,
    output logic               mem_wb_writereg,
    output logic [DATA_W-1:0]  mem_wb_wbvalue,
    output logic               mem_err
);

    localparam logic [WdogW-1:0] Limit = WdogW'(TIMEOUT_CYCLES);

    state_e state_q, state_d;

    logic [RegIdxW-1:0] cap_regdest_q;
    logic               cap_writereg_q;
    logic               cap_selw_q;
    logic               cap_rw_q;
    logic [DATA_W-1:0]  cap_addr_q;
    logic [DATA_W-1:0]  cap_wdata_q;

    logic [RegIdxW-1:0] wb_regdest_q;
    logic               wb_writereg_q;
    logic [DATA_W-1:0]  wb_wbvalue_q;
    logic               err_q;

    logic mem_op;
    logic in_access;
    logic expired;
    logic wdog_clear;
    logic wdog_enable;

    assign mem_op      = ex_mem_readmem | ex_mem_writemem;
    assign in_access   = (state_q == StAccess);
    assign wdog_clear  = (state_q == StIdle) && mem_op;
    assign wdog_enable = in_access && !mem_dm_ready && !expired;

    mem_watchdog u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .clear   (wdog_clear),
        .enable  (wdog_enable),
        .limit   (Limit),
        .expired (expired)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Ready takes priority over expiry on the abort edge.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (mem_op) state_d = StAccess;
            StAccess: if (mem_dm_ready || expired) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_dm_en    = in_access;
        mem_ex_stall = in_access;
        mem_dm_rw    = in_access ? cap_rw_q : DmRead;
        mem_dm_addr  = in_access ? cap_addr_q : '0;
        mem_dm_wdata = in_access ? cap_wdata_q : '0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cap_regdest_q  <= '0;
            cap_writereg_q <= 1'b0;
            cap_selw_q     <= 1'b0;
            cap_rw_q       <= DmRead;
            cap_addr_q     <= '0;
            cap_wdata_q    <= '0;
            wb_regdest_q   <= '0;
            wb_writereg_q  <= 1'b0;
            wb_wbvalue_q   <= '0;
            err_q          <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (mem_op) begin
                        cap_regdest_q  <= ex_mem_regdest;
                        cap_writereg_q <= ex_mem_writereg;
                        cap_selw_q     <= ex_mem_selwsource;
                        cap_rw_q       <= ex_mem_writemem ? DmWrite : DmRead;
                        cap_addr_q     <= ex_mem_wbvalue;
                        cap_wdata_q    <= ex_mem_regb;
                        wb_writereg_q  <= 1'b0;
                    end else begin
                        wb_regdest_q  <= ex_mem_regdest;
                        wb_writereg_q <= ex_mem_writereg;
                        wb_wbvalue_q  <= ex_mem_wbvalue;
                    end
                end
                StAccess: begin
                    if (mem_dm_ready) begin
                        wb_regdest_q  <= cap_regdest_q;
                        wb_writereg_q <= cap_writereg_q;
                        wb_wbvalue_q  <= (cap_selw_q && (cap_rw_q == DmRead)) ?
                                         mem_dm_rdata : cap_addr_q;
                    end else if (expired) begin
                        wb_writereg_q <= 1'b0;
                        err_q         <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_wb_regdest  = wb_regdest_q;
    assign mem_wb_writereg = wb_writereg_q;
    assign mem_wb_wbvalue  = wb_wbvalue_q;
    assign mem_err         = err_q;

endmodule
